// File: rtl/uart_tx_if.sv
// Byte-stream handshake between a bus-side producer and the UART transmitter FIFO.
interface uart_tx_if #(
    parameter int DataWidth = 8
) ();
    logic [DataWidth-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: input FIFO feeding a start/data/parity/stop serialiser
// that advances one bit per baud tick and chains frames without idle gaps.
module uart_tx #(
    parameter int DataWidth = 8,
    parameter int FifoDepth = 4,
    parameter int ParityEn  = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       tick_i,
    uart_tx_if.slave                   bus,
    output logic                       tx_o,
    output logic                       busy_o,
    output logic                       tx_done_o,
    output logic [$clog2(FifoDepth):0] level_o
);
    localparam int PtrW = $clog2(FifoDepth);
    localparam int LvlW = PtrW + 1;
    localparam int CntW = $clog2(DataWidth) + 1;

    typedef enum logic [2:0] {
        Idle,
        StartBit,
        DataBits,
        ParityBit,
        StopBit
    } state_t;

    state_t               state_q, state_n;
    logic [DataWidth-1:0] shift_q, shift_n;
    logic                 par_q, par_n;
    logic [CntW-1:0]      cnt_q, cnt_n;
    logic                 tx_q, tx_n;
    logic                 done_q, done_n;

    logic [DataWidth-1:0] mem [FifoDepth];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]      level_q;
    logic                 push, pop, have_data;
    logic [DataWidth-1:0] head;

    assign bus.ready = (level_q != LvlW'(FifoDepth));
    assign push      = bus.valid && bus.ready;
    assign have_data = (level_q != '0);
    assign head      = mem[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LvlW'(1);
                2'b01:   level_q <= level_q - LvlW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Load path is shared by Idle and StopBit so back-to-back frames chain directly.
    always_comb begin
        state_n = state_q;
        shift_n = shift_q;
        par_n   = par_q;
        cnt_n   = cnt_q;
        tx_n    = tx_q;
        done_n  = 1'b0;
        pop     = 1'b0;
        if (tick_i) begin
            case (state_q)
                Idle: begin
                    tx_n = 1'b1;
                    if (have_data) begin
                        pop     = 1'b1;
                        shift_n = head;
                        par_n   = ^head;
                        tx_n    = 1'b0;
                        state_n = StartBit;
                    end
                end
                StartBit: begin
                    state_n = DataBits;
                    tx_n    = shift_q[0];
                    cnt_n   = '0;
                end
                DataBits: begin
                    if (cnt_q == CntW'(DataWidth - 1)) begin
                        if (ParityEn != 0) begin
                            state_n = ParityBit;
                            tx_n    = par_q;
                        end else begin
                            state_n = StopBit;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        shift_n = shift_q >> 1;
                        cnt_n   = cnt_q + CntW'(1);
                        tx_n    = shift_n[0];
                    end
                end
                ParityBit: begin
                    state_n = StopBit;
                    tx_n    = 1'b1;
                end
                StopBit: begin
                    done_n = 1'b1;
                    if (have_data) begin
                        pop     = 1'b1;
                        shift_n = head;
                        par_n   = ^head;
                        tx_n    = 1'b0;
                        state_n = StartBit;
                    end else begin
                        tx_n    = 1'b1;
                        state_n = Idle;
                    end
                end
                default: begin
                    tx_n    = 1'b1;
                    state_n = Idle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= Idle;
            shift_q <= '0;
            par_q   <= 1'b0;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            shift_q <= shift_n;
            par_q   <= par_n;
            cnt_q   <= cnt_n;
            tx_q    <= tx_n;
            done_q  <= done_n;
        end
    end

    assign tx_o      = tx_q;
    assign busy_o    = (state_q != Idle);
    assign tx_done_o = done_q;
    assign level_o   = level_q;
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one instance without parity, one with even parity,
// sharing clock, reset and baud tick.
module tb_uart_tx;
    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       tx0, busy0, done0;
    logic       tx1, busy1, done1;
    logic [2:0] lvl0, lvl1;

    int total = 0;
    int bad   = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;

    always #5 clk = ~clk;

    uart_tx_if #(.DataWidth(8)) bus0 ();
    uart_tx_if #(.DataWidth(8)) bus1 ();

    uart_tx #(.DataWidth(8), .FifoDepth(4), .ParityEn(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .tick_i(tick), .bus(bus0),
        .tx_o(tx0), .busy_o(busy0), .tx_done_o(done0), .level_o(lvl0)
    );

    uart_tx #(.DataWidth(8), .FifoDepth(4), .ParityEn(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .tick_i(tick), .bus(bus1),
        .tx_o(tx1), .busy_o(busy1), .tx_done_o(done1), .level_o(lvl1)
    );

    always @(posedge clk) begin
        if (done0) done_cnt0 <= done_cnt0 + 1;
        if (done1) done_cnt1 <= done_cnt1 + 1;
    end

    typedef struct {
        bit          sel;
        logic [7:0]  data;
        int          nbits;
        logic [10:0] exp;
    } vec_t;

    vec_t       vecs [7];
    logic [7:0] burst [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_tick(input bit sel, output logic b);
        tick = 1'b1;
        step();
        tick = 1'b0;
        b = sel ? tx1 : tx0;
    endtask

    task automatic push(input bit sel, input logic [7:0] d);
        if (sel) begin
            bus1.data = d; bus1.valid = 1'b1; step(); bus1.valid = 1'b0;
        end else begin
            bus0.data = d; bus0.valid = 1'b1; step(); bus0.valid = 1'b0;
        end
    endtask

    // Push one byte into an empty idle instance and capture the whole frame.
    task automatic run_frame(input bit sel, input logic [7:0] d, input int nbits,
                             input logic [10:0] exp);
        logic [10:0] got;
        logic        b;
        int          d0;
        d0 = sel ? done_cnt1 : done_cnt0;
        push(sel, d);
        check("level_after_push", sel ? lvl1 : lvl0, 1);
        check("tx_idle_before_tick", sel ? tx1 : tx0, 1);
        check("busy_before_tick", sel ? busy1 : busy0, 0);
        got = '0;
        for (int k = 0; k < nbits; k++) begin
            do_tick(sel, b);
            got[k] = b;
            if (k == 0) check("busy_in_frame", sel ? busy1 : busy0, 1);
            step();
            step();
        end
        do_tick(sel, b);
        check("tx_after_stop", b, 1);
        step();
        check("busy_after_frame", sel ? busy1 : busy0, 0);
        check("done_pulses", (sel ? done_cnt1 : done_cnt0) - d0, 1);
        check("frame_bits", got, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        b;
        logic [59:0] stream;
        logic [19:0] stuck;
        int          d0;

        vecs[0] = '{1'b0, 8'hA5, 10, 11'b01101001010};
        vecs[1] = '{1'b1, 8'h07, 11, 11'b11000001110};
        vecs[2] = '{1'b1, 8'hA5, 11, 11'b10101001010};
        vecs[3] = '{1'b0, 8'h00, 10, 11'b01000000000};
        vecs[4] = '{1'b1, 8'h01, 11, 11'b11000000010};
        vecs[5] = '{1'b1, 8'h80, 11, 11'b11100000000};
        vecs[6] = '{1'b0, 8'h3C, 10, 11'b01001111000};
        burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
        burst[3] = 8'h44; burst[4] = 8'h55; burst[5] = 8'h66;

        rst = 1'b1; tick = 1'b0;
        bus0.valid = 1'b0; bus0.data = '0;
        bus1.valid = 1'b0; bus1.data = '0;
        step();
        step();
        check("rst_tx0", tx0, 1);
        check("rst_busy0", busy0, 0);
        check("rst_done0", done0, 0);
        check("rst_level0", lvl0, 0);
        check("rst_ready0", bus0.ready, 1);
        check("rst_tx1", tx1, 1);
        check("rst_level1", lvl1, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].sel, vecs[i].data, vecs[i].nbits, vecs[i].exp);
        end

        // Burst of five with no ticks, then a refill on a StopBit->StartBit pop.
        d0 = done_cnt0;
        bus0.valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus0.data = burst[i];
            step();
        end
        check("burst_level_full", lvl0, 4);
        check("burst_ready_low", bus0.ready, 0);
        bus0.data = burst[4];
        step();
        step();
        check("fifth_held_ready", bus0.ready, 0);
        check("fifth_held_level", lvl0, 4);
        for (int i = 0; i < 60; i++) begin
            if (i == 10) begin
                bus0.valid = 1'b1;
                bus0.data  = burst[5];
                check("stop_pop_full_ready", bus0.ready, 0);
                check("stop_pop_full_level", lvl0, 4);
            end
            do_tick(1'b0, b);
            stream[i] = b;
            if (i == 0 || i == 10) begin
                check("level_after_pop", lvl0, 3);
                check("ready_after_pop", bus0.ready, 1);
                step();
                check("level_after_refill", lvl0, 4);
                bus0.valid = 1'b0;
                step();
            end else begin
                step();
                step();
            end
        end
        do_tick(1'b0, b);
        check("burst_tx_idle", b, 1);
        step();
        check("burst_busy_end", busy0, 0);
        check("burst_level_end", lvl0, 0);
        check("burst_done_pulses", done_cnt0 - d0, 6);
        for (int f = 0; f < 6; f++) begin
            check("burst_frame", stream[f*10 +: 10], {1'b1, burst[f], 1'b0});
        end

        // Reset mid-frame with bytes still queued.
        push(1'b0, 8'h3C);
        push(1'b0, 8'h01);
        push(1'b0, 8'h02);
        check("pre_rst_level", lvl0, 3);
        for (int i = 0; i < 4; i++) begin
            do_tick(1'b0, b);
            step();
        end
        check("pre_rst_busy", busy0, 1);
        check("pre_rst_level_popped", lvl0, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_tx", tx0, 1);
        check("mid_rst_level", lvl0, 0);
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_ready", bus0.ready, 1);
        step();
        run_frame(1'b0, 8'h55, 10, 11'b01010101010);

        // Tick held high: one bit per cycle.
        push(1'b0, 8'hFF);
        d0 = done_cnt0;
        tick = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            stuck[i] = tx0;
        end
        tick = 1'b0;
        step();
        check("stuck_tick_bits", stuck, 20'hFFFFE);
        check("stuck_tick_busy", busy0, 0);
        check("stuck_tick_done", done_cnt0 - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
